// File: rtl/gcd_unit_pkg.sv
`default_nettype none
// gcd_unit_pkg -- shared FSM encoding and width default for the GCD unit.
// Rev 1.0
package gcd_unit_pkg;

  localparam int unsigned GCD_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } gcd_state_e;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic a_zero;
    logic b_zero;
  } dp_flags_t;

endpackage
`default_nettype wire

// File: rtl/gcd_unit_data_path.sv
`default_nettype none
// data_path -- A/B operand registers, shared subtractor, comparator and zero flags.
// Rev 1.0
module data_path
  import gcd_unit_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             ldA_i,
  input  logic             ldB_i,
  input  logic             sel1_i,
  input  logic             sel2_i,
  input  logic             selIn_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output dp_flags_t        flags_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] w_minuend;
  logic [WIDTH-1:0] w_subtrahend;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_load_val;

  // sel1=1/sel2=1 forms B-A, which also yields B when A is zero (the A<=B case).
  always_comb begin
    w_minuend    = sel1_i ? b_q : a_q;
    w_subtrahend = sel2_i ? a_q : b_q;
    w_diff       = w_minuend - w_subtrahend;
    w_load_val   = selIn_i ? data_in_i : w_diff;
    a_d          = ldA_i ? w_load_val : a_q;
    b_d          = ldB_i ? w_load_val : b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  always_comb begin
    flags_o.lt     = (a_q < b_q);
    flags_o.gt     = (a_q > b_q);
    flags_o.eq     = (a_q == b_q);
    flags_o.a_zero = (a_q == '0);
    flags_o.b_zero = (b_q == '0);
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule
`default_nettype wire

// File: rtl/gcd_unit.sv
`default_nettype none
// gcd_unit -- subtractive GCD: serial operand load, one subtract per cycle, Moore done flag.
// Rev 1.0
module gcd_unit
  import gcd_unit_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  gcd_state_e state_q;
  logic       done_q;
  dp_flags_t  w_flags;
  logic       w_ldA, w_ldB, w_sel1, w_sel2, w_selIn;
  logic       w_finish;

  data_path #(
    .WIDTH (WIDTH)
  ) u_data_path (
    .clk       (clk),
    .rst       (rst),
    .data_in_i (data_in),
    .ldA_i     (w_ldA),
    .ldB_i     (w_ldB),
    .sel1_i    (w_sel1),
    .sel2_i    (w_sel2),
    .selIn_i   (w_selIn),
    .a_o       (a_out),
    .b_o       (b_out),
    .flags_o   (w_flags)
  );

  assign w_finish = w_flags.b_zero | w_flags.a_zero | w_flags.eq;

  always_comb begin
    w_ldA   = 1'b0;
    w_ldB   = 1'b0;
    w_sel1  = 1'b0;
    w_sel2  = 1'b0;
    w_selIn = 1'b0;
    unique case (state_q)
      S_LOAD_A: begin
        w_ldA   = 1'b1;
        w_selIn = 1'b1;
      end
      S_LOAD_B: begin
        w_ldB   = 1'b1;
        w_selIn = 1'b1;
      end
      S_COMPUTE: begin
        if (w_flags.b_zero) begin
          w_ldA = 1'b0;
        end else if (w_flags.a_zero) begin
          w_ldA  = 1'b1;
          w_sel1 = 1'b1;
          w_sel2 = 1'b1;
        end else if (w_flags.gt) begin
          w_ldA = 1'b1;
        end else if (w_flags.lt) begin
          w_ldB  = 1'b1;
          w_sel1 = 1'b1;
          w_sel2 = 1'b1;
        end
      end
      default: begin
        w_ldA = 1'b0;
      end
    endcase
  end

  // done is registered alongside the state so it rises on the same edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) state_q <= S_LOAD_A;
        end
        S_LOAD_A: begin
          done_q  <= 1'b0;
          state_q <= S_LOAD_B;
        end
        S_LOAD_B: begin
          done_q  <= 1'b0;
          state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (w_finish) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            done_q  <= 1'b0;
          end
        end
        S_DONE: begin
          if (!start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done    = done_q;
  assign gcd_out = a_out;

endmodule
`default_nettype wire

// File: tb/tb_gcd_unit.sv
`default_nettype none
// tb_gcd_unit -- randomized scoreboard bench for gcd_unit against an arithmetic reference model.
// Rev 1.0
module tb_gcd_unit;

  localparam int unsigned WIDTH = 8;
  localparam int TIMEOUT = 600;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] gcd_out;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;

  gcd_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .done    (done),
    .gcd_out (gcd_out),
    .a_out   (a_out),
    .b_out   (b_out)
  );

  typedef struct {
    int a;
    int b;
    int g;
    int lat;
    int t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  logic done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: subtractive Euclid collapsed into quotient steps; lat = subtractions + 1.
  function automatic void ref_gcd(input int a_in, input int b_in, output int g, output int lat);
    int a, b, k, subs;
    a = a_in;
    b = b_in;
    subs = 0;
    if (b == 0) begin
      g = a; lat = 1; return;
    end
    if (a == 0) begin
      g = b; lat = 1; return;
    end
    while (a != b) begin
      if (a > b) begin
        k = (a - 1) / b; subs += k; a -= k * b;
      end else begin
        k = (b - 1) / a; subs += k; b -= k * a;
      end
    end
    g = a;
    lat = subs + 1;
  endfunction

  // Monitor: every rising done pops one expectation.
  always @(negedge clk) begin
    if (!rst && done && !done_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got gcd_out=%0d expected no completion", gcd_out);
      end else begin
        mon_item = sb.pop_front();
        check($sformatf("gcd(%0d,%0d)", mon_item.a, mon_item.b), int'(gcd_out), mon_item.g);
        check($sformatf("latency(%0d,%0d)", mon_item.a, mon_item.b), cyc - mon_item.t0, mon_item.lat);
      end
    end
    done_prev = done;
  end

  task automatic load_ops(input int a, input int b);
    exp_t it;
    @(negedge clk);
    start   = 1'b1;
    data_in = WIDTH'($urandom);
    @(negedge clk);
    data_in = WIDTH'(a);
    @(negedge clk);
    data_in = WIDTH'(b);
    @(negedge clk);
    data_in = WIDTH'($urandom);
    it.a  = a;
    it.b  = b;
    it.t0 = cyc;
    ref_gcd(a, b, it.g, it.lat);
    sb.push_back(it);
  endtask

  task automatic run_op(input int a, input int b, input int hold, input bit trace);
    int exp_a [4];
    int exp_b [4];
    int waited;
    load_ops(a, b);
    if (trace) begin
      exp_a = '{68, 17, 17, 17};
      exp_b = '{51, 51, 34, 17};
      check("trace_load_a", int'(a_out), a);
      check("trace_load_b", int'(b_out), b);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check($sformatf("trace_a[%0d]", i), int'(a_out), exp_a[i]);
        check($sformatf("trace_b[%0d]", i), int'(b_out), exp_b[i]);
        check($sformatf("trace_done[%0d]", i), int'(done), 0);
      end
    end
    waited = 0;
    while (!done && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout(%0d,%0d): got done=0 expected done within %0d cycles", a, b, TIMEOUT);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_held", int'(done), 1);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_cleared", int'(done), 0);
  endtask

  task automatic abort_op(input int a, input int b, input int k);
    load_ops(a, b);
    repeat (k) @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("abort_done", int'(done), 0);
    check("abort_a", int'(a_out), 0);
    check("abort_b", int'(b_out), 0);
    check("abort_gcd", int'(gcd_out), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_abort_idle_done", int'(done), 0);
    check("post_abort_idle_a", int'(a_out), 0);
  endtask

  initial begin
    int ra, rb;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    #1;
    check("reset_done", int'(done), 0);
    check("reset_gcd", int'(gcd_out), 0);
    check("reset_a", int'(a_out), 0);
    check("reset_b", int'(b_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(119, 51, 0, 1'b1);
    run_op(36, 36, 0, 1'b0);
    run_op(0, 25, 0, 1'b0);
    run_op(25, 0, 0, 1'b0);
    run_op(0, 0, 0, 1'b0);
    run_op(255, 1, 0, 1'b0);
    abort_op(200, 3, 10);
    run_op(48, 18, 0, 1'b0);
    run_op(91, 35, 3, 1'b0);
    run_op(21, 14, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      run_op(ra, rb, int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
